// File: rtl/output_delta_pkg.sv
`default_nettype none
// ============================================================================
// Module      : output_delta_pkg
// Description : Shared fixed-point constants, FSM encodings and saturating
//               arithmetic helpers for the output-layer delta stage.
// Revision    : 1.0 - initial release
// ============================================================================
package output_delta_pkg;

    localparam int DWIDTH = 32;
    localparam int FRAC   = 24;

    localparam logic signed [DWIDTH-1:0] ONE     = DWIDTH'(1) << FRAC;
    localparam logic signed [DWIDTH-1:0] SAT_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [DWIDTH-1:0] SAT_MIN = 32'sh8000_0000;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Both helpers work one bit wider so the overflow shows up in the sign pair.
    function automatic logic signed [DWIDTH-1:0] sat_add(
        input logic signed [DWIDTH-1:0] a,
        input logic signed [DWIDTH-1:0] b
    );
        logic signed [DWIDTH:0] s;
        s = {a[DWIDTH-1], a} + {b[DWIDTH-1], b};
        if (s[DWIDTH] != s[DWIDTH-1])
            return s[DWIDTH] ? SAT_MIN : SAT_MAX;
        return s[DWIDTH-1:0];
    endfunction

    function automatic logic signed [DWIDTH-1:0] sat_sub(
        input logic signed [DWIDTH-1:0] a,
        input logic signed [DWIDTH-1:0] b
    );
        logic signed [DWIDTH:0] s;
        s = {a[DWIDTH-1], a} - {b[DWIDTH-1], b};
        if (s[DWIDTH] != s[DWIDTH-1])
            return s[DWIDTH] ? SAT_MIN : SAT_MAX;
        return s[DWIDTH-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/output_delta_fxp_mul.sv
`default_nettype none
// ============================================================================
// Module      : fxp_mul
// Description : Combinational signed Q8.24 multiply, arithmetic >>FRAC,
//               saturated back to DWIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module fxp_mul
    import output_delta_pkg::*;
(
    input  logic signed [DWIDTH-1:0] a,
    input  logic signed [DWIDTH-1:0] b,
    output logic signed [DWIDTH-1:0] p
);

    logic signed [2*DWIDTH-1:0] w_full;
    logic signed [2*DWIDTH-1:0] w_shift;
    logic signed [2*DWIDTH-1:0] w_max;
    logic signed [2*DWIDTH-1:0] w_min;

    assign w_full  = 64'(a) * 64'(b);
    assign w_shift = w_full >>> FRAC;
    assign w_max   = 64'(SAT_MAX);
    assign w_min   = 64'(SAT_MIN);

    always_comb begin
        if (w_shift > w_max)
            p = SAT_MAX;
        else if (w_shift < w_min)
            p = SAT_MIN;
        else
            p = w_shift[DWIDTH-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/output_delta.sv
`default_nettype none
// ============================================================================
// Module      : output_delta
// Description : Output-layer backprop deltas and SSE using one time-shared
//               saturating fixed-point multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module output_delta
    import output_delta_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DWIDTH-1:0] y1,
    input  logic signed [DWIDTH-1:0] y2,
    input  logic signed [DWIDTH-1:0] t1,
    input  logic signed [DWIDTH-1:0] t2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DWIDTH-1:0] delta1,
    output logic signed [DWIDTH-1:0] delta2,
    output logic signed [DWIDTH-1:0] sse
);

    localparam logic [2:0] c_last_step = 3'd6;

    logic [1:0]               r_state;
    logic [2:0]               r_step;
    logic signed [DWIDTH-1:0] r_y1, r_y2, r_e1, r_e2;
    logic signed [DWIDTH-1:0] r_p, r_d1, r_d2, r_acc;

    logic signed [DWIDTH-1:0] w_y_sel;
    logic signed [DWIDTH-1:0] w_omy;
    logic signed [DWIDTH-1:0] w_a, w_b, w_prod;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);

    // Steps 0-2 work on output 1, steps 3-5 on output 2.
    assign w_y_sel = (r_step < 3'd3) ? r_y1 : r_y2;
    assign w_omy   = sat_sub(ONE, w_y_sel);

    always_comb begin
        w_a = w_y_sel;
        w_b = w_omy;
        case (r_step)
            3'd1:    begin w_a = r_e1; w_b = r_p;  end
            3'd2:    begin w_a = r_e1; w_b = r_e1; end
            3'd4:    begin w_a = r_e2; w_b = r_p;  end
            3'd5:    begin w_a = r_e2; w_b = r_e2; end
            default: begin w_a = w_y_sel; w_b = w_omy; end
        endcase
    end

    fxp_mul u_mul (
        .a (w_a),
        .b (w_b),
        .p (w_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_step  <= 3'd0;
            r_y1    <= '0;
            r_y2    <= '0;
            r_e1    <= '0;
            r_e2    <= '0;
            r_p     <= '0;
            r_d1    <= '0;
            r_d2    <= '0;
            r_acc   <= '0;
            delta1  <= '0;
            delta2  <= '0;
            sse     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_y1    <= y1;
                        r_y2    <= y2;
                        r_e1    <= sat_sub(y1, t1);
                        r_e2    <= sat_sub(y2, t2);
                        r_acc   <= '0;
                        r_step  <= 3'd0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_step <= r_step + 3'd1;
                    case (r_step)
                        3'd0: r_p   <= w_prod;
                        3'd1: r_d1  <= w_prod;
                        3'd2: r_acc <= w_prod;
                        3'd3: r_p   <= w_prod;
                        3'd4: r_d2  <= w_prod;
                        3'd5: r_acc <= sat_add(r_acc, w_prod);
                        c_last_step: begin
                            // Outputs change only here, on entry to DONE.
                            delta1  <= r_d1;
                            delta2  <= r_d2;
                            sse     <= r_acc;
                            r_state <= S_DONE;
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
                S_DONE: begin
                    if (out_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
